// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bus lock in front of the single-port data memory.
// One access accepted per cycle; the response is registered one cycle after acceptance.
module dmem_arbiter #(
  parameter int MEM_SIZE = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req0_lock,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic        req1_lock,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic             prio, prio_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

  logic        grant0, grant1, timeout, accept;
  logic        win_we, win_lock, win_in_range;
  logic [31:0] win_addr, win_wdata;

  // Winner selection. A lock owner that is not releasing this cycle loses
  // ownership once the hold counter hits LOCK_MAX.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant0  = 1'b0;
    grant1  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant0 = !prio;
          grant1 = prio;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      OWN0: begin
        if (lock_cnt >= CNT_W'(LOCK_MAX) && !(req0_valid && !req0_lock)) timeout = 1'b1;
        else grant0 = req0_valid;
      end
      OWN1: begin
        if (lock_cnt >= CNT_W'(LOCK_MAX) && !(req1_valid && !req1_lock)) timeout = 1'b1;
        else grant1 = req1_valid;
      end
      default: ;
    endcase
    if (!reset_n) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;

  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (grant0) begin
      win_we    = req0_we;
      win_lock  = req0_lock;
      win_addr  = req0_addr;
      win_wdata = req0_wdata;
    end else if (grant1) begin
      win_we    = req1_we;
      win_lock  = req1_lock;
      win_addr  = req1_addr;
      win_wdata = req1_wdata;
    end
  end

  assign win_in_range = win_addr < 32'(MEM_SIZE);
  assign mem_a        = win_addr;
  assign mem_wd       = win_wdata;
  assign mem_we       = accept && win_we && win_in_range;

  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    lock_cnt_nxt = '0;
    if (accept) begin
      prio_nxt = grant0;
      if (win_lock) state_nxt = grant0 ? OWN0 : OWN1;
      else          state_nxt = IDLE;
    end else if (timeout) begin
      state_nxt = IDLE;
      prio_nxt  = (state == OWN0);
    end
    // Counter restarts on entering an OWN state and runs while it is held.
    if (state != IDLE && state_nxt != IDLE) lock_cnt_nxt = lock_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      lock_cnt    <= '0;
      resp0_valid <= 1'b0;
      resp0_err   <= 1'b0;
      resp0_rdata <= '0;
      resp1_valid <= 1'b0;
      resp1_err   <= 1'b0;
      resp1_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= state_nxt;
      prio        <= prio_nxt;
      lock_cnt    <= lock_cnt_nxt;
      resp0_valid <= grant0;
      resp0_err   <= grant0 && !win_in_range;
      resp0_rdata <= (grant0 && !win_we && win_in_range) ? mem_rd : '0;
      resp1_valid <= grant1;
      resp1_err   <= grant1 && !win_in_range;
      resp1_rdata <= (grant1 && !win_we && win_in_range) ? mem_rd : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter, checked against a cycle-level
// behavioural model of ownership, fairness and the attached memory.
module tb_dmem_arbiter;

  localparam int MEM_SIZE = 64;
  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        resp0_valid, resp0_err;
  logic [31:0] resp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        resp1_valid, resp1_err;
  logic [31:0] resp1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 8) return 32'h00023BFF;
    if (i == 9) return 32'h000239DF;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // Attached dmem: combinational read, write on the rising edge.
  logic [31:0] dmem [MEM_SIZE];
  assign mem_rd = dmem[mem_a[5:0]];
  initial begin
    for (int i = 0; i < MEM_SIZE; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) dmem[mem_a[5:0]] <= mem_wd;
    end
  end

  // Reference model state: owner -1 means nobody holds the lock.
  int          checks = 0;
  int          errors = 0;
  int          owner, held, prio_m;
  bit          erv [2];
  bit          ere [2];
  logic [31:0] erd [2];
  logic [31:0] exp_mem [MEM_SIZE];
  bit          obs_r1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit lk);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd; req0_lock = lk;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd; req1_lock = lk;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready0"}, 32'(req0_ready), 32'd0);
    check({tag, "_ready1"}, 32'(req1_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_resp0"}, {resp0_rdata[29:0], resp0_valid, resp0_err}, 32'd0);
    check({tag, "_resp1"}, {resp1_rdata[29:0], resp1_valid, resp1_err}, 32'd0);
    check({tag, "_rdata_hi"}, {30'd0, resp0_rdata[31:30] | resp1_rdata[31:30]}, 32'd0);
  endtask

  // Enter reset at any point in a cycle; the model forgets ownership and pending responses.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_quiet({tag, "_async"});
    owner = -1; held = 0; prio_m = 0;
    for (int p = 0; p < 2; p++) begin erv[p] = 0; ere[p] = 0; erd[p] = '0; end
    @(posedge clk); #1;
    check_quiet({tag, "_held"});
    reset_n = 1'b1;
  endtask

  // One clock cycle: predict and compare at the falling edge, then advance the model.
  task automatic run_cycle();
    bit          v [2];
    bit          we [2];
    bit          lk [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    int          win;
    bit          tout, exp_we;
    logic [31:0] ea, ewd;
    @(negedge clk);
    v[0] = req0_valid; we[0] = req0_we; lk[0] = req0_lock; ad[0] = req0_addr; wd[0] = req0_wdata;
    v[1] = req1_valid; we[1] = req1_we; lk[1] = req1_lock; ad[1] = req1_addr; wd[1] = req1_wdata;
    win = -1; tout = 0;
    if (owner < 0) begin
      if (v[0] && v[1]) win = prio_m;
      else if (v[0])    win = 0;
      else if (v[1])    win = 1;
    end else if (held >= LOCK_MAX && !(v[owner] && !lk[owner])) tout = 1;
    else if (v[owner]) win = owner;
    ea     = (win >= 0) ? ad[win] : 32'd0;
    ewd    = (win >= 0) ? wd[win] : 32'd0;
    exp_we = (win >= 0) && we[win] && (ea < 32'(MEM_SIZE));
    obs_r1 = req1_ready;
    check("ready0", 32'(req0_ready), 32'(win == 0));
    check("ready1", 32'(req1_ready), 32'(win == 1));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_a", mem_a, ea);
    check("mem_wd", mem_wd, ewd);
    check("resp0_valid", 32'(resp0_valid), 32'(erv[0]));
    check("resp0_err", 32'(resp0_err), 32'(ere[0]));
    check("resp0_rdata", resp0_rdata, erd[0]);
    check("resp1_valid", 32'(resp1_valid), 32'(erv[1]));
    check("resp1_err", 32'(resp1_err), 32'(ere[1]));
    check("resp1_rdata", resp1_rdata, erd[1]);
    for (int p = 0; p < 2; p++) begin
      erv[p] = (win == p);
      ere[p] = (win == p) && (ad[p] >= 32'(MEM_SIZE));
      erd[p] = ((win == p) && !we[p] && ad[p] < 32'(MEM_SIZE)) ? exp_mem[ad[p][5:0]] : 32'd0;
    end
    if (exp_we) exp_mem[ea[5:0]] = ewd;
    if (win >= 0) begin
      prio_m = 1 - win;
      if (lk[win]) begin
        if (owner < 0) begin owner = win; held = 0; end
        else held++;
      end else owner = -1;
    end else if (tout) begin
      prio_m = 1 - owner;
      owner  = -1;
    end else if (owner >= 0) held++;
    @(posedge clk); #1;
  endtask

  initial begin
    int idle_cnt;
    for (int i = 0; i < MEM_SIZE; i++) exp_mem[i] = init_word(i);
    owner = -1; held = 0; prio_m = 0;
    for (int p = 0; p < 2; p++) begin erv[p] = 0; ere[p] = 0; erd[p] = '0; end

    // Reset with both ports requesting, then six cycles of contention on addresses 8 and 9.
    drive(0, 1, 0, 32'd8, 32'd0, 0);
    drive(1, 1, 0, 32'd9, 32'd0, 0);
    apply_reset("rst");
    repeat (6) run_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 0);
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    run_cycle();

    // Port 1 write followed by read-back of the same word.
    drive(1, 1, 1, 32'd20, 32'hDEADBEEF, 0);
    run_cycle();
    drive(1, 1, 0, 32'd20, 32'd0, 0);
    run_cycle();
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    check("raw_readback", resp1_rdata, 32'hDEADBEEF);
    run_cycle();

    // Lock: port 0 read with lock, write releasing it, port 1 requesting throughout.
    drive(1, 1, 0, 32'd5, 32'd0, 0);
    drive(0, 1, 0, 32'd12, 32'd0, 1);
    run_cycle();
    drive(0, 1, 1, 32'd12, 32'h12345678, 0);
    run_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 0);
    run_cycle();
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    run_cycle();

    // Out of range write, then read of the top legal word.
    drive(0, 1, 1, 32'd64, 32'hCAFEF00D, 0);
    run_cycle();
    drive(0, 1, 0, 32'd63, 32'd0, 0);
    run_cycle();
    drive(0, 1, 0, 32'hFFFF_FFFF, 32'd0, 0);
    run_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 0);
    run_cycle();

    // Lock timeout: port 0 takes the lock and goes silent while port 1 waits.
    drive(0, 1, 0, 32'd3, 32'd0, 1);
    run_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 0);
    drive(1, 1, 0, 32'd5, 32'd0, 0);
    idle_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      run_cycle();
      if (obs_r1) break;
      idle_cnt++;
    end
    check("timeout_wait", 32'(idle_cnt), 32'(LOCK_MAX + 1));
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    run_cycle();

    // Reset while port 0 holds the lock; afterwards port 0 wins a tie again.
    drive(1, 1, 0, 32'd7, 32'd0, 0);
    drive(0, 1, 0, 32'd10, 32'd0, 1);
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    run_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 0);
    drive(1, 1, 0, 32'd7, 32'd0, 0);
    repeat (2) run_cycle();
    drive(0, 1, 0, 32'd11, 32'd0, 0);
    apply_reset("midlock");
    run_cycle();
    check("midlock_prio", 32'(obs_r1), 32'd0);

    // Randomized traffic, including occasional out-of-range addresses, locks and resets.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'(MEM_SIZE) + $urandom_range(0, 1000);
        else if (r == 1) a = $urandom;
        else             a = $urandom_range(0, MEM_SIZE - 1);
        drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom,
              $urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 99) == 0) apply_reset("rand_rst");
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory `dmem`. It shares `dmem` between the core load/store unit (port 0) and a debug/DMA requester (port 1). It accepts at most one access per cycle, with round-robin fairness and an optional bus lock for read-modify-write sequences. It suppresses out-of-range accesses and returns a registered response one cycle after acceptance.

## Interface

Parameters:
- `MEM_SIZE`, 64: number of 32-bit words in the attached `dmem`. The legal word address range is `0..MEM_SIZE-1`.
- `LOCK_MAX`, 16: maximum number of consecutive cycles a lock may be held before it is forcibly revoked.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: port 0 request present.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_we` in 1: 1 = write, 0 = read.
- `req0_addr` in 32: word address.
- `req0_wdata` in 32: write data.
- `req0_lock` in 1: keep ownership after this access.
- `resp0_valid` out 1: port 0 response strobe.
- `resp0_rdata` out 32: read data.
- `resp0_err` out 1: address out of range.
- Port 1 has the same nine signals (`req1_*`, `resp1_*`).
- `mem_we` out 1: to `dmem` `WE`.
- `mem_a` out 32: to `dmem` `A`.
- `mem_wd` out 32: to `dmem` `WD`.
- `mem_rd` in 32: from `dmem` `RD`, combinational read.

## Operation

- **States:**
  - `IDLE`: normal round-robin.
  - `OWN0`: port 0 holds the lock.
  - `OWN1`: port 1 holds the lock.
- **Priority pointer `prio`:** reset value 0, meaning port 0 wins a tie.
- **Winner selection in `IDLE`:**
  - If exactly one `reqX_valid` is high, that port wins.
  - If both are high, port `prio` wins.
- **Winner selection in `OWNx`:** only port x can win. The other port's `ready` is held at 0 even when its `valid` is high.
- **Ready and accept:** `reqX_ready` is combinational and equals (port X is the winner). An access is accepted when `valid && ready`.
- **Pointer update:** after port X is accepted, `prio` is set to the other port.
- **Memory drive:**
  - `mem_a` and `mem_wd` carry the winner's `addr` and `wdata`. With no winner, both are 0.
  - `mem_we = accepted && we && (addr < MEM_SIZE)`.
- **Out of range (`addr >= MEM_SIZE`, full 32-bit unsigned compare):**
  - No write reaches memory.
  - The response has `err=1` and `rdata=0`.
- **Response:**
  - Registered. In the cycle after acceptance, `respX_valid=1` and `respX_err` is set.
  - `respX_rdata` is the `mem_rd` value sampled during the accept cycle for an in-range read, and 0 for writes or errors.
  - Response outputs are 0 in every cycle without a response.
- **Lock transitions:**
  - `IDLE` → `OWNx`: port x is accepted with `lock=1`.
  - `OWNx` → `IDLE`: port x is accepted with `lock=0`. That access is still performed.
  - An accepted erroring access still obeys `lock`.
- **Lock timeout:**
  - `lock_cnt` resets to 0 when an `OWN` state is entered and increments every cycle in `OWNx`.
  - When it reaches `LOCK_MAX` (and no accept is releasing the lock in that same cycle), the arbiter forces `IDLE` and sets `prio` to the other port.
  - Nothing is accepted from port x in that cycle.
- **Reset (asynchronous, any time including mid-lock or mid-response):**
  - State returns to `IDLE`, `prio=0`, `lock_cnt=0`.
  - All `resp*` outputs go to 0.
  - Any pending response is dropped.
  - `mem_we` goes to 0 because nothing is valid-accepted while `reset_n=0`, and `ready` is forced to 0.

## Timing

- **Accept cycle N:**
  - A write commits at the rising edge that ends cycle N.
  - A read samples `mem_rd` in cycle N.
  - The response appears in cycle N+1 and lasts exactly one cycle.
- **Throughput:** one access per cycle. Back-to-back accepts on the same or alternating ports are allowed.
- **Overlap:** a response for access N and the accept of access N+1 occur in the same cycle.
- **Read after write:** a read in cycle N+1 of the address written in cycle N returns the new data.
- **Lock release:** the accept with `lock=0` releases the lock. In the following cycle the other port may win.

## Test plan

- **Reset and idle:** hold `reset_n=0` with both ports valid. Expect `ready0=ready1=0`, `mem_we=0`, all `resp*=0`. Release reset and expect port 0 to win the first cycle.
- **Contention fairness:** keep both ports continuously valid for 6 cycles with reads of addresses 8 and 9. Expect grants to alternate 0,1,0,1,0,1. With `dmem` reset contents, `resp0_rdata=0x00023BFF` and `resp1_rdata=0x000239DF`, each arriving one cycle after its grant.
- **Write then read:** port 1 writes `0xDEADBEEF` to address 20, then reads it back the next cycle. Expect `mem_we=1` only in the write cycle and `resp1_rdata=0xDEADBEEF` for the read.
- **Out of range:** port 0 writes to address 64 with `MEM_SIZE=64`. Expect `mem_we=0`, then `resp0_err=1` and `rdata=0` in the next cycle. A following read of address 63 is unchanged.
- **Lock:** port 0 issues a read with `lock=1`, then a write with `lock=0`, while port 1 stays valid throughout. Expect `ready1=0` during both port 0 accesses, and port 1 granted in the cycle after the release.
- **Timeout and reset mid-lock:**
  - Port 0 takes the lock and then drops `valid`. After `LOCK_MAX=16` cycles, port 1 is granted.
  - Repeat, but assert `reset_n=0` mid-lock. Expect an immediate return to `IDLE` with `prio=0`.
